// File: rtl/wb_slave_dummy_response.sv
// -----------------------------------------------------------------------------
// wb_slave_dummy_response
//
// Dummy Wishbone slave. It answers classic and incrementing-burst read/write
// cycles from a small internal register file. A programmable number of wait
// states precedes the first ack of each cycle. Use it as a traffic sink, or as
// a deterministic target for bus/NoC latency and handshake tests.
//
// Optional feature (macro WB_SLAVE_DUMMY_ERR_EN):
//   defined   - an access with any address bit above the register-file index
//               set ends with s_err_o instead of s_ack_o. The timing is the
//               same. No write happens and s_dat_o keeps its value.
//   undefined - s_err_o is tied to 0. Upper address bits are ignored, so such
//               addresses alias onto the register file.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-high reset
//   s_dat_i   in   [Dw-1:0]    write data
//   s_sel_i   in   [SELw-1:0]  byte enables
//   s_addr_i  in   [S_Aw-1:0]  word address
//   s_cti_i   in   [TAGw-1:0]  cycle type (000 classic, 010 incr burst, 111 end)
//   s_stb_i   in   strobe
//   s_cyc_i   in   cycle
//   s_we_i    in   1 = write
//   s_dat_o   out  [Dw-1:0]    read data
//   s_ack_o   out  acknowledge
//   s_err_o   out  error
//   s_rty_o   out  retry (always 0)
// -----------------------------------------------------------------------------
module wb_slave_dummy_response #(
    parameter int Dw                = 32,
    parameter int S_Aw              = 7,
    parameter int TAGw              = 3,
    parameter int SELw              = 4,
    parameter int MEM_Aw            = 3,
    parameter int ACK_DELAY_CLK_NUM = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Dw-1:0]   s_dat_i,
    input  logic [SELw-1:0] s_sel_i,
    input  logic [S_Aw-1:0] s_addr_i,
    input  logic [TAGw-1:0] s_cti_i,
    input  logic            s_stb_i,
    input  logic            s_cyc_i,
    input  logic            s_we_i,
    output logic [Dw-1:0]   s_dat_o,
    output logic            s_ack_o,
    output logic            s_err_o,
    output logic            s_rty_o
);

    localparam int WORDS = 2 ** MEM_Aw;
    // The counter must hold values 0..ACK_DELAY_CLK_NUM, and it is at least 1 bit wide.
    localparam int CNT_W = (ACK_DELAY_CLK_NUM < 2) ? 1 : $clog2(ACK_DELAY_CLK_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (ACK_DELAY_CLK_NUM > 0) ? CNT_W'(ACK_DELAY_CLK_NUM - 1) : '0;

    localparam logic [TAGw-1:0] CTI_CLASSIC = TAGw'(3'b000);
    localparam logic [TAGw-1:0] CTI_INCR    = TAGw'(3'b010);
    localparam logic [TAGw-1:0] CTI_END     = TAGw'(3'b111);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BURST
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [MEM_Aw-1:0]   addr_reg, addr_next;
    logic [Dw-1:0]       dat_reg, dat_next;
    logic [Dw-1:0]       mem_reg [WORDS];

    logic                req;
    logic                out_of_range;
    logic [Dw-1:0]       rd_word;
    logic [Dw-1:0]       wr_word;
    logic                mem_we;
    logic                ack;
    logic                err;
    logic [Dw-1:0]       dat_out;

    assign req     = s_stb_i & s_cyc_i;
    assign rd_word = mem_reg[addr_reg];

`ifdef WB_SLAVE_DUMMY_ERR_EN
    assign out_of_range = |s_addr_i[S_Aw-1:MEM_Aw];
`else
    assign out_of_range = 1'b0;
`endif

    // The upper address bits only matter when error reporting is built in.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, s_addr_i[S_Aw-1:MEM_Aw]};

    // Byte-lane merge for a read-modify-write of the addressed word.
    generate
        for (genvar gi = 0; gi < SELw; gi++) begin : g_lane
            assign wr_word[gi*8 +: 8] = s_sel_i[gi] ? s_dat_i[gi*8 +: 8] : rd_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        dat_next   = dat_reg;
        mem_we     = 1'b0;
        ack        = 1'b0;
        err        = 1'b0;
        dat_out    = dat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    addr_next  = s_addr_i[MEM_Aw-1:0];
                    cnt_next   = '0;
                    state_next = (ACK_DELAY_CLK_NUM > 0) ? ST_WAIT : ST_ACK;
                end
            end

            ST_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_ACK;
                end
            end

            ST_ACK: begin
                state_next = ST_IDLE;
                if (out_of_range) begin
                    err = 1'b1;
                end else begin
                    ack = 1'b1;
                    if (s_we_i) begin
                        mem_we = 1'b1;
                    end else begin
                        dat_next = rd_word;
                        dat_out  = rd_word;
                    end
                    if (s_cti_i == CTI_INCR) begin
                        state_next = ST_BURST;
                        addr_next  = addr_reg + 1'b1;
                    end
                end
            end

            ST_BURST: begin
                // The read path is combinational here, so beats need no wait states.
                if (!s_we_i && !out_of_range) begin
                    dat_out = rd_word;
                end
                if (!s_cyc_i) begin
                    state_next = ST_IDLE;
                end else if (s_stb_i) begin
                    if (out_of_range) begin
                        err        = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ack       = 1'b1;
                        addr_next = addr_reg + 1'b1;
                        if (s_we_i) begin
                            mem_we = 1'b1;
                        end else begin
                            dat_next = rd_word;
                        end
                        if (s_cti_i == CTI_END || s_cti_i == CTI_CLASSIC) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            dat_reg   <= dat_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (mem_we) begin
            mem_reg[addr_reg] <= wr_word;
        end
    end

    // The outputs are decoded from the registered state, so an asynchronous reset drops ack at once.
    assign s_ack_o = ack;
    assign s_err_o = err;
    assign s_dat_o = dat_out;
    assign s_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_slave_dummy_response.sv
module tb_wb_slave_dummy_response;

    localparam int ACK_DELAY = 2;
    // The request is driven mid-cycle and sampled at the next edge T.
    // Ack is then due in cycle T+1+ACK_DELAY, which is the (ACK_DELAY+2)-th
    // falling edge after the drive.
    localparam int LAT_FIRST = ACK_DELAY + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_dat_i;
    logic [3:0]  s_sel_i;
    logic [6:0]  s_addr_i;
    logic [2:0]  s_cti_i;
    logic        s_stb_i;
    logic        s_cyc_i;
    logic        s_we_i;
    logic [31:0] s_dat_o;
    logic        s_ack_o;
    logic        s_err_o;
    logic        s_rty_o;

    wb_slave_dummy_response #(
        .Dw(32), .S_Aw(7), .TAGw(3), .SELw(4), .MEM_Aw(3),
        .ACK_DELAY_CLK_NUM(ACK_DELAY)
    ) dut (
        .clk(clk), .reset(reset),
        .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_addr_i(s_addr_i),
        .s_cti_i(s_cti_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_we_i(s_we_i),
        .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        ack;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [8];
    logic [31:0] last_rd;
    int          total;
    int          passes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Drive one request/beat and push the expected response.
    task automatic beat(input logic we, input logic [6:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input logic [2:0] cti, input int lat);
        exp_t e;
        logic [2:0] idx;
        logic       oor;
        @(posedge clk); #1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
        s_addr_i = addr; s_dat_i = data; s_sel_i = sel; s_cti_i = cti;
        idx = addr[2:0];
`ifdef WB_SLAVE_DUMMY_ERR_EN
        oor = (addr[6:3] != 4'd0);
`else
        oor = 1'b0;
`endif
        e.lat = lat;
        if (oor) begin
            e.ack = 1'b0; e.err = 1'b1; e.chk_data = 1'b1; e.data = last_rd;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            e.ack = 1'b1; e.err = 1'b0; e.chk_data = 1'b0; e.data = '0;
        end else begin
            e.ack = 1'b1; e.err = 1'b0; e.chk_data = 1'b1; e.data = model[idx];
            last_rd = model[idx];
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) for ack/err, then pop the scoreboard and compare.
    task automatic wait_resp(input string tag);
        exp_t e;
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (s_ack_o || s_err_o) seen = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        chk({tag, "_ack"}, {31'd0, s_ack_o}, {31'd0, e.ack});
        chk({tag, "_err"}, {31'd0, s_err_o}, {31'd0, e.err});
        if (e.chk_data) chk({tag, "_dat"}, s_dat_o, e.data);
        $display("txn %s: lat=%0d ack=%0b err=%0b dat=0x%08h", tag, n, s_ack_o, s_err_o, s_dat_o);
    endtask

    task automatic end_cycle(input string tag);
        @(posedge clk); #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_cti_i = 3'b000; s_we_i = 1'b0;
        @(negedge clk);
        chk({tag, "_noack"}, {31'd0, s_ack_o}, 32'd0);
    endtask

    task automatic classic(input string tag, input logic we, input logic [6:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
        beat(we, addr, data, sel, 3'b000, LAT_FIRST);
        wait_resp(tag);
        end_cycle(tag);
    endtask

    initial begin
        total = 0; passes = 0; last_rd = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        reset = 1'b1; s_cyc_i = 0; s_stb_i = 0; s_we_i = 0;
        s_addr_i = '0; s_dat_i = '0; s_sel_i = '0; s_cti_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state held over 5 idle cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_ack", {31'd0, s_ack_o}, 32'd0);
            chk("rst_err", {31'd0, s_err_o}, 32'd0);
            chk("rst_dat", s_dat_o, 32'd0);
        end
        chk("rty", {31'd0, s_rty_o}, 32'd0);
        $display("txn reset: idle checks done");

        // Classic full write, read back, then a partial-lane write.
        classic("wr3", 1'b1, 7'd3, 32'hDEADBEEF, 4'b1111);
        classic("rd3", 1'b0, 7'd3, 32'h0, 4'b1111);
        classic("wr3_lane1", 1'b1, 7'd3, 32'h0000AA00, 4'b0010);
        classic("rd3_merge", 1'b0, 7'd3, 32'h0, 4'b1111);
        chk("merge_const", model[3], 32'hDEADAAEF);

        // Incrementing write burst from 6, wrapping to 0 and 1.
        beat(1'b1, 7'd6, 32'd1, 4'hF, 3'b010, LAT_FIRST); wait_resp("bw0");
        beat(1'b1, 7'd7, 32'd2, 4'hF, 3'b010, 1);         wait_resp("bw1");
        beat(1'b1, 7'd0, 32'd3, 4'hF, 3'b010, 1);         wait_resp("bw2");
        beat(1'b1, 7'd1, 32'd4, 4'hF, 3'b111, 1);         wait_resp("bw3");
        end_cycle("bw_end");
        classic("rd6", 1'b0, 7'd6, 32'h0, 4'hF);
        classic("rd7", 1'b0, 7'd7, 32'h0, 4'hF);
        classic("rd0", 1'b0, 7'd0, 32'h0, 4'hF);
        classic("rd1", 1'b0, 7'd1, 32'h0, 4'hF);

        // Out-of-range address: an error with the feature, aliasing onto word 0 without it.
        classic("rd8", 1'b0, 7'h08, 32'h0, 4'hF);

        // Abort: cyc drops during WAIT, so no ack is given.
        @(posedge clk); #1;
        s_cyc_i = 1; s_stb_i = 1; s_we_i = 0; s_addr_i = 7'd3; s_cti_i = 3'b000;
        @(posedge clk); #1;
        s_cyc_i = 0; s_stb_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_noack", {31'd0, s_ack_o}, 32'd0);
        end
        $display("txn abort: no ack observed window done");
        classic("rd3_after_abort", 1'b0, 7'd3, 32'h0, 4'hF);

        // Reset asserted during WAIT clears everything.
        @(posedge clk); #1;
        s_cyc_i = 1; s_stb_i = 1; s_we_i = 0; s_addr_i = 7'd5; s_cti_i = 3'b000;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rstwait_ack", {31'd0, s_ack_o}, 32'd0);
        chk("rstwait_dat", s_dat_o, 32'd0);
        @(posedge clk); #1;
        s_cyc_i = 0; s_stb_i = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstwait_noack", {31'd0, s_ack_o}, 32'd0);
        end
        $display("txn reset_in_wait: done");
        for (int i = 0; i < 8; i++) classic($sformatf("clr%0d", i), 1'b0, 7'(i), 32'h0, 4'hF);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Global time limit so the run always terminates on its own.
    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", passes, total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_slave_dummy_response.md
Name: wb_slave_dummy_response

Overview:
- Dummy Wishbone slave: the responder end of the dummy read-request master.
- Answers classic and incrementing-burst read/write cycles from a small internal register file, with a programmable number of wait states before the first ack.
- Placed on a bus slave port as a traffic sink, or as a deterministic target for NoC/bus latency and handshake tests.

Parameters:
- Dw, 32, data width.
- S_Aw, 7, slave word-address width.
- TAGw, 3, CTI width.
- SELw, 4, byte-select width (Dw/8).
- MEM_Aw, 3, register-file index width; 2**MEM_Aw words of Dw bits.
- ACK_DELAY_CLK_NUM, 2, wait states between request sampling and first ack (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- s_dat_i  in  Dw  write data.
- s_sel_i  in  SELw  byte enables.
- s_addr_i  in  S_Aw  word address.
- s_cti_i  in  TAGw  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- s_stb_i  in  1  strobe.
- s_cyc_i  in  1  cycle.
- s_we_i  in  1  1 = write.
- s_dat_o  out  Dw  read data.
- s_ack_o  out  1  acknowledge.
- s_err_o  out  1  error; constant 0 unless WB_SLAVE_DUMMY_ERR_EN.
- s_rty_o  out  1  retry; constant 0.

Behaviour:
- Reset (already decided): reset reset, asynchronous, active-high; clock clk.
- On reset:
  - state=IDLE, wait counter=0, burst address=0.
  - all 2**MEM_Aw words=0.
  - s_dat_o=0, s_ack_o=0, s_err_o=0.
  - Reset mid-cycle drops ack immediately; nothing pending is committed.
- Request = s_stb_i & s_cyc_i. Word index = s_addr_i[MEM_Aw-1:0]; upper address bits ignored (aliasing).
- Wait counter width: max(1, log2(ACK_DELAY_CLK_NUM+1)).
- States:
  - IDLE: on request, latch index into the burst address, load counter=0. Next state is WAIT if ACK_DELAY_CLK_NUM>0, else ACK.
  - WAIT: counter increments each cycle. On counter==ACK_DELAY_CLK_NUM-1, go to ACK. If request drops, abort to IDLE with no ack and no write.
  - ACK: s_ack_o=1 for exactly this cycle.
    - Read: s_dat_o = mem[burst address].
    - Write: mem[burst address] updated per s_sel_i byte lanes at the end of this cycle.
    - If s_cti_i==010 go to BURST, burst address +1 (wraps modulo 2**MEM_Aw); else go to IDLE.
- Latency: a request sampled at edge T gives ack high in cycle T+1+ACK_DELAY_CLK_NUM.
- BURST:
  - s_ack_o = s_stb_i & s_cyc_i (combinational); zero wait states per beat.
  - Each acked beat reads or writes mem[burst address], then increments it.
  - Beat with s_cti_i==111, or s_cti_i==000, is acked and then returns to IDLE.
  - s_cyc_i low: IDLE without ack. s_stb_i low with s_cyc_i high: hold BURST, no ack.
- s_dat_o:
  - Holds the last read value outside ack cycles.
  - In BURST it is a combinational read of mem[burst address].
  - Writes never change it.
- Back-to-back classic cycles: at least one IDLE cycle between acks; a held request re-samples in IDLE and starts a new cycle.
- s_we_i and s_dat_i are sampled at the ack cycle, not at request sampling.

Optional Feature:
- Macro: WB_SLAVE_DUMMY_ERR_EN.
- Defined:
  - Any access with s_addr_i[S_Aw-1:MEM_Aw] != 0 completes with s_err_o=1 instead of s_ack_o, at the same cycle timing.
  - No memory write; s_dat_o unchanged.
  - In BURST, an out-of-range beat errors and returns to IDLE.
- Undefined: s_err_o tied 0 and out-of-range addresses alias.

Test Plan:
- Reset, then idle 5 cycles -> s_ack_o=0, s_err_o=0, s_dat_o=0.
- Classic write at addr 3, data 0xDEADBEEF, sel 1111, ACK_DELAY=2; request at edge T -> single ack in cycle T+3. A following classic read of addr 3 returns 0xDEADBEEF with the same latency.
- Write at addr 3 with sel 0010, data 0x0000AA00 -> subsequent read of addr 3 returns 0xDEADAAEF.
- Incrementing burst of 4 writes from addr 6 (cti 010,010,010,111), data 1..4 -> first ack after 2 wait states, then 3 consecutive acks; mem[6]=1, mem[7]=2, mem[0]=3, mem[1]=4 (wrap). Return to IDLE.
- Read request; cyc deasserted during WAIT -> no ack, state IDLE; the next request gets full ACK_DELAY latency. Separately, assert reset during WAIT -> no ack, all words read back 0.
- With WB_SLAVE_DUMMY_ERR_EN, read of addr 0x08 (MEM_Aw=3) -> s_err_o=1 in cycle T+3, s_ack_o=0, s_dat_o unchanged. Without the macro, the same read acks with mem[0].
